// File: rtl/compensation_pe_mc_pkg.sv
// Shared accelerator constants for the compensation PE: default widths and
// lane-slice helpers used by the PE, its lane MAC and the bus interface.
package compensation_pe_mc_pkg;

  localparam int CPE_LANES  = 2;
  localparam int CPE_ACT_W  = 7;
  localparam int CPE_CW_W   = 3;
  localparam int CPE_PSUM_W = CPE_ACT_W + CPE_CW_W + 3;
  localparam int CPE_SAT    = 1;

  // Bit offset of a lane inside a lane-packed bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Width of the full-precision product of the expanded activation and weight.
  function automatic int prod_width(input int act_w, input int cw_w);
    return act_w + cw_w + 2;
  endfunction

endpackage

// File: rtl/compensation_pe_mc_if.sv
// Bus bundle for one compensation PE: weight load/forward, activation in/out,
// lane-packed partial sums and status. master = upstream driver, slave = PE.
interface compensation_pe_mc_if
  import compensation_pe_mc_pkg::*;
#(
  parameter int LANES  = CPE_LANES,
  parameter int ACT_W  = CPE_ACT_W,
  parameter int CW_W   = CPE_CW_W,
  parameter int PSUM_W = ACT_W + CW_W + 3
) ();

  logic                    w_load_valid;
  logic [LANES*CW_W-1:0]   w_load_data;
  logic                    w_swap;
  logic                    w_pass_valid;
  logic [LANES*CW_W-1:0]   w_pass_data;
  logic                    act_valid;
  logic [ACT_W-1:0]        act_data;
  logic                    act_out_valid;
  logic [ACT_W-1:0]        act_out;
  logic [LANES*PSUM_W-1:0] psum_in;
  logic [LANES*PSUM_W-1:0] psum_out;
  logic                    cfg_bypass;
  logic                    w_active_valid;
  logic [LANES-1:0]        ovf;

  modport master (
    output w_load_valid, w_load_data, w_swap, act_valid, act_data, psum_in, cfg_bypass,
    input  w_pass_valid, w_pass_data, act_out_valid, act_out, psum_out, w_active_valid, ovf
  );

  modport slave (
    input  w_load_valid, w_load_data, w_swap, act_valid, act_data, psum_in, cfg_bypass,
    output w_pass_valid, w_pass_data, act_out_valid, act_out, psum_out, w_active_valid, ovf
  );

endinterface

// File: rtl/compensation_pe_mc_lane_mac.sv
// One compensation lane: ({act,1} * {w,1}) + psum_in with carry detection.
// Purely combinational; the enclosing PE registers the result and carry.
module cpe_lane_mac
  import compensation_pe_mc_pkg::*;
#(
  parameter int ACT_W  = CPE_ACT_W,
  parameter int CW_W   = CPE_CW_W,
  parameter int PSUM_W = ACT_W + CW_W + 3,
  parameter int SAT    = CPE_SAT
) (
  input  logic [ACT_W-1:0]  act,
  input  logic [CW_W-1:0]   w,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [PSUM_W-1:0] psum_res,
  output logic              carry
);

  localparam int PROD_W = prod_width(ACT_W, CW_W);

  logic [PROD_W-1:0] prod;
  logic [PSUM_W:0]   sum;

  // Stored values drop the implicit LSB of 1; restore it, multiply and accumulate.
  always_comb begin
    prod  = PROD_W'({act, 1'b1}) * PROD_W'({w, 1'b1});
    sum   = {1'b0, psum_in} + (PSUM_W + 1)'(prod);
    carry = sum[PSUM_W];
    if (carry && (SAT != 0)) begin
      psum_res = '1;
    end else begin
      psum_res = sum[PSUM_W-1:0];
    end
  end

endmodule

// File: rtl/compensation_pe_mc.sv
// Multi-lane compensation PE: one shared activation, double-buffered weights.
// psum/act/weight forwards all have 1-cycle latency; no backpressure (streaming).
module compensation_pe_mc
  import compensation_pe_mc_pkg::*;
#(
  parameter int LANES  = CPE_LANES,
  parameter int ACT_W  = CPE_ACT_W,
  parameter int CW_W   = CPE_CW_W,
  parameter int PSUM_W = ACT_W + CW_W + 3,
  parameter int SAT    = CPE_SAT
) (
  input  logic              clk,
  input  logic              rst_n,
  compensation_pe_mc_if.slave io
);

  logic [LANES*CW_W-1:0]   shadow_q, shadow_d;
  logic [LANES*CW_W-1:0]   active_q, active_d;
  logic                    shadow_valid_q, shadow_valid_d;
  logic                    w_active_valid_q, w_active_valid_d;
  logic [LANES-1:0]        ovf_q, ovf_d;
  logic [LANES*PSUM_W-1:0] psum_q, psum_d;
  logic [ACT_W-1:0]        act_out_q, act_out_d;
  logic                    act_out_valid_q, act_out_valid_d;
  logic [LANES*CW_W-1:0]   w_pass_data_q, w_pass_data_d;
  logic                    w_pass_valid_q, w_pass_valid_d;

  logic [LANES*PSUM_W-1:0] lane_res;
  logic [LANES-1:0]        lane_carry;
  logic                    compute;

  // One MAC per lane, all fed from the active bank (never the shadow).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cpe_lane_mac #(
      .ACT_W  (ACT_W),
      .CW_W   (CW_W),
      .PSUM_W (PSUM_W),
      .SAT    (SAT)
    ) u_mac (
      .act      (io.act_data),
      .w        (active_q[lane_lsb(i, CW_W) +: CW_W]),
      .psum_in  (io.psum_in[lane_lsb(i, PSUM_W) +: PSUM_W]),
      .psum_res (lane_res[lane_lsb(i, PSUM_W) +: PSUM_W]),
      .carry    (lane_carry[i])
    );
  end

  assign compute = io.act_valid & w_active_valid_q & ~io.cfg_bypass;

  // Next-state: bank management, overflow tracking, psum select and forwards.
  always_comb begin
    shadow_d         = shadow_q;
    active_d         = active_q;
    shadow_valid_d   = shadow_valid_q;
    w_active_valid_d = w_active_valid_q;
    ovf_d            = ovf_q;
    psum_d           = io.psum_in;
    act_out_d        = io.act_data;
    act_out_valid_d  = io.act_valid;
    w_pass_data_d    = io.w_load_data;
    w_pass_valid_d   = io.w_load_valid;

    if (io.w_load_valid) begin
      shadow_d       = io.w_load_data;
      shadow_valid_d = 1'b1;
    end

    // A swap takes the old shadow; a load in the same cycle refills it.
    if (io.w_swap) begin
      ovf_d = '0;
      if (shadow_valid_q) begin
        active_d         = shadow_q;
        w_active_valid_d = 1'b1;
        shadow_valid_d   = io.w_load_valid;
      end
    end

    // This cycle computes with the pre-swap bank; its carries survive a same-cycle clear.
    if (compute) begin
      psum_d = lane_res;
      ovf_d  = ovf_d | lane_carry;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q         <= '0;
      active_q         <= '0;
      shadow_valid_q   <= 1'b0;
      w_active_valid_q <= 1'b0;
      ovf_q            <= '0;
      psum_q           <= '0;
      act_out_q        <= '0;
      act_out_valid_q  <= 1'b0;
      w_pass_data_q    <= '0;
      w_pass_valid_q   <= 1'b0;
    end else begin
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      shadow_valid_q   <= shadow_valid_d;
      w_active_valid_q <= w_active_valid_d;
      ovf_q            <= ovf_d;
      psum_q           <= psum_d;
      act_out_q        <= act_out_d;
      act_out_valid_q  <= act_out_valid_d;
      w_pass_data_q    <= w_pass_data_d;
      w_pass_valid_q   <= w_pass_valid_d;
    end
  end

  assign io.psum_out       = psum_q;
  assign io.ovf            = ovf_q;
  assign io.w_active_valid = w_active_valid_q;
  assign io.act_out        = act_out_q;
  assign io.act_out_valid  = act_out_valid_q;
  assign io.w_pass_data    = w_pass_data_q;
  assign io.w_pass_valid   = w_pass_valid_q;

endmodule

// File: tb/tb_compensation_pe_mc.sv
// Bench for compensation_pe_mc: saturating and wrapping instances share stimulus,
// directed scenarios then random traffic against an arithmetic reference model.
module tb_compensation_pe_mc;

  localparam int L  = 2;
  localparam int AW = 7;
  localparam int CW = 3;
  localparam int PW = AW + CW + 3;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic            w_load_valid = 1'b0;
  logic [L*CW-1:0] w_load_data  = '0;
  logic            w_swap       = 1'b0;
  logic            act_valid    = 1'b0;
  logic [AW-1:0]   act_data     = '0;
  logic [L*PW-1:0] psum_in      = '0;
  logic            cfg_bypass   = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  compensation_pe_mc_if #(.LANES(L), .ACT_W(AW), .CW_W(CW), .PSUM_W(PW)) if_s ();
  compensation_pe_mc_if #(.LANES(L), .ACT_W(AW), .CW_W(CW), .PSUM_W(PW)) if_w ();

  assign if_s.w_load_valid = w_load_valid;
  assign if_s.w_load_data  = w_load_data;
  assign if_s.w_swap       = w_swap;
  assign if_s.act_valid    = act_valid;
  assign if_s.act_data     = act_data;
  assign if_s.psum_in      = psum_in;
  assign if_s.cfg_bypass   = cfg_bypass;
  assign if_w.w_load_valid = w_load_valid;
  assign if_w.w_load_data  = w_load_data;
  assign if_w.w_swap       = w_swap;
  assign if_w.act_valid    = act_valid;
  assign if_w.act_data     = act_data;
  assign if_w.psum_in      = psum_in;
  assign if_w.cfg_bypass   = cfg_bypass;

  compensation_pe_mc #(.LANES(L), .ACT_W(AW), .CW_W(CW), .PSUM_W(PW), .SAT(1))
    dut_s (.clk(clk), .rst_n(rst_n), .io(if_s));
  compensation_pe_mc #(.LANES(L), .ACT_W(AW), .CW_W(CW), .PSUM_W(PW), .SAT(0))
    dut_w (.clk(clk), .rst_n(rst_n), .io(if_w));

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int     m_act_w [L];
  int     m_sh_w  [L];
  bit     m_sh_v, m_act_v;
  bit [L-1:0] m_ovf;
  int     e_sat [L];
  int     e_wrap[L];
  int     e_act_out;
  bit     e_act_v;
  int     e_wpass;
  bit     e_wpass_v;

  function automatic int lane_psum_in(int i);
    logic [L*PW-1:0] v;
    v = psum_in;
    return int'(v[i*PW +: PW]);
  endfunction

  function automatic int lane_w(int i);
    logic [L*CW-1:0] v;
    v = w_load_data;
    return int'(v[i*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_act_w[i] = 0; m_sh_w[i] = 0; e_sat[i] = 0; e_wrap[i] = 0;
    end
    m_sh_v = 0; m_act_v = 0; m_ovf = '0;
    e_act_out = 0; e_act_v = 0; e_wpass = 0; e_wpass_v = 0;
  endtask

  // Effect of one rising edge, evaluated on the inputs present at that edge.
  task automatic model_step();
    bit         use_it;
    bit [L-1:0] carries;
    int         old_sh[L];
    int         s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    use_it  = act_valid && m_act_v && !cfg_bypass;
    carries = '0;
    for (int i = 0; i < L; i++) begin
      if (use_it) begin
        s = lane_psum_in(i) + (2 * int'(act_data) + 1) * (2 * m_act_w[i] + 1);
        if (s > PMAX) begin
          carries[i] = 1'b1;
          e_sat[i]   = PMAX;
          e_wrap[i]  = s - (PMAX + 1);
        end else begin
          e_sat[i]  = s;
          e_wrap[i] = s;
        end
      end else begin
        e_sat[i]  = lane_psum_in(i);
        e_wrap[i] = lane_psum_in(i);
      end
    end
    m_ovf = (w_swap ? '0 : m_ovf) | carries;
    for (int i = 0; i < L; i++) old_sh[i] = m_sh_w[i];
    if (w_swap && m_sh_v) begin
      for (int i = 0; i < L; i++) m_act_w[i] = old_sh[i];
      m_act_v = 1;
      m_sh_v  = 0;
    end
    if (w_load_valid) begin
      for (int i = 0; i < L; i++) m_sh_w[i] = lane_w(i);
      m_sh_v = 1;
    end
    e_act_out = int'(act_data);
    e_act_v   = act_valid;
    e_wpass   = int'(w_load_data);
    e_wpass_v = w_load_valid;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("%s_sat_psum%0d", tag, i), 32'(if_s.psum_out[i*PW +: PW]), 32'(e_sat[i]));
      chk($sformatf("%s_wrap_psum%0d", tag, i), 32'(if_w.psum_out[i*PW +: PW]), 32'(e_wrap[i]));
    end
    chk({tag, "_sat_ovf"},  32'(if_s.ovf), 32'(m_ovf));
    chk({tag, "_wrap_ovf"}, 32'(if_w.ovf), 32'(m_ovf));
    chk({tag, "_wact_v"},   32'(if_s.w_active_valid), 32'(m_act_v));
    chk({tag, "_act_out"},  32'(if_s.act_out), 32'(e_act_out));
    chk({tag, "_act_out_v"}, 32'(if_s.act_out_valid), 32'(e_act_v));
    chk({tag, "_wpass"},    32'(if_s.w_pass_data), 32'(e_wpass));
    chk({tag, "_wpass_v"},  32'(if_s.w_pass_valid), 32'(e_wpass_v));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    w_load_valid = 0; w_swap = 0; act_valid = 0; cfg_bypass = 0;
  endtask

  task automatic load_w(input int w);
    w_load_valid = 1;
    for (int i = 0; i < L; i++) w_load_data[i*CW +: CW] = CW'(w);
  endtask

  task automatic set_psum(input int p);
    for (int i = 0; i < L; i++) psum_in[i*PW +: PW] = PW'(p);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_psum_s"}, 32'(if_s.psum_out), 0);
    chk({tag, "_psum_w"}, 32'(if_w.psum_out), 0);
    chk({tag, "_ovf"},    32'(if_s.ovf), 0);
    chk({tag, "_wact_v"}, 32'(if_s.w_active_valid), 0);
    chk({tag, "_act_out"}, 32'(if_s.act_out), 0);
    chk({tag, "_act_v"},  32'(if_s.act_out_valid), 0);
    chk({tag, "_wpass"},  32'(if_s.w_pass_data), 0);
    chk({tag, "_wpass_v"}, 32'(if_s.w_pass_valid), 0);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;

    // No swap since reset: act passes psum_in through
    act_valid = 1; act_data = 7'd9; set_psum(42);
    cycle("noswap");
    chk("noswap_psum0", 32'(if_s.psum_out[PW-1:0]), 42);
    chk("noswap_wact_v", 32'(if_s.w_active_valid), 0);

    // Load w=2, swap, act=5 psum=100 -> 155
    idle(); load_w(2);
    cycle("load2");
    idle(); w_swap = 1;
    cycle("swap2");
    idle(); act_valid = 1; act_data = 7'd5; set_psum(100);
    cycle("mac155");
    chk("mac155_psum0", 32'(if_s.psum_out[PW-1:0]), 155);
    chk("mac155_psum1", 32'(if_w.psum_out[2*PW-1:PW]), 155);
    chk("mac155_ovf", 32'(if_s.ovf), 0);

    // Overflow: w=7 act=127 psum=8000
    idle(); load_w(7);
    cycle("load7");
    idle(); w_swap = 1;
    cycle("swap7");
    idle(); act_valid = 1; act_data = 7'd127; set_psum(8000);
    cycle("ovf");
    chk("ovf_sat_psum0", 32'(if_s.psum_out[PW-1:0]), 8191);
    chk("ovf_wrap_psum0", 32'(if_w.psum_out[PW-1:0]), 3633);
    chk("ovf_sat_flag", 32'(if_s.ovf), 3);
    chk("ovf_wrap_flag", 32'(if_w.ovf), 3);
    idle();
    cycle("ovf_sticky");
    chk("ovf_sticky_flag", 32'(if_s.ovf), 3);

    // Swap in same cycle as act uses the pre-swap bank
    load_w(1);
    cycle("load1");
    idle(); w_swap = 1;
    cycle("swap1");
    idle(); load_w(3);
    cycle("load3");
    idle(); w_swap = 1; act_valid = 1; act_data = 7'd5; set_psum(10);
    cycle("swapact");
    chk("swapact_psum0", 32'(if_s.psum_out[PW-1:0]), 43);
    idle(); act_valid = 1;
    cycle("postswap");
    chk("postswap_psum0", 32'(if_s.psum_out[PW-1:0]), 87);

    // Simultaneous load(4)+swap with shadow 2
    idle(); load_w(2);
    cycle("load2b");
    idle(); load_w(4); w_swap = 1;
    cycle("loadswap");
    idle(); act_valid = 1; act_data = 7'd5; set_psum(0);
    cycle("use2");
    chk("use2_psum0", 32'(if_s.psum_out[PW-1:0]), 55);
    idle(); w_swap = 1;
    cycle("swap4");
    idle(); act_valid = 1;
    cycle("use4");
    chk("use4_psum0", 32'(if_s.psum_out[PW-1:0]), 99);
    idle(); w_swap = 1;
    cycle("swap_empty");
    idle(); act_valid = 1;
    cycle("use4b");
    chk("use4b_psum1", 32'(if_s.psum_out[2*PW-1:PW]), 99);
    chk("use4b_wact_v", 32'(if_s.w_active_valid), 1);

    // Bypass forces pass-through
    cfg_bypass = 1; set_psum(1234);
    cycle("bypass");
    chk("bypass_psum0", 32'(if_s.psum_out[PW-1:0]), 1234);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      w_load_valid = ($urandom_range(3) == 0);
      w_load_data  = (L*CW)'($urandom);
      w_swap       = ($urandom_range(6) == 0);
      act_valid    = ($urandom_range(9) < 7);
      act_data     = AW'($urandom);
      cfg_bypass   = ($urandom_range(9) == 0);
      psum_in      = (L*PW)'({$urandom, $urandom});
      cycle("rand");
    end

    // Mid-stream asynchronous reset
    idle(); load_w(5); w_swap = 1; act_valid = 1; act_data = 7'd100; set_psum(77);
    cycle("pre_rst");
    #2;
    rst_n = 0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(); act_valid = 1; act_data = 7'd5; set_psum(42);
    cycle("post_rst");
    chk("post_rst_psum0", 32'(if_s.psum_out[PW-1:0]), 42);
    chk("post_rst_wact_v", 32'(if_s.w_active_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/compensation_pe_mc.md
COMPENSATION_PE_MC -- requirements
Module: compensation_pe_mc

Interface
REQ-001 SHALL have parameter LANES, default 2: number of compensation channels sharing one activation.
REQ-002 SHALL have parameter ACT_W, default 7: stored activation magnitude bits.
REQ-003 SHALL have parameter CW_W, default 3: stored compensation weight bits per lane.
REQ-004 SHALL have parameter PSUM_W, default ACT_W+CW_W+3 (13): partial-sum width per lane.
REQ-005 SHALL have parameter SAT, default 1: 1 = saturate on overflow, 0 = wrap.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port w_load_valid  input  1  shadow weight write strobe.
REQ-009 SHALL have port w_load_data  input  LANES*CW_W  weights, lane i at bits [i*CW_W +: CW_W].
REQ-010 SHALL have port w_swap  input  1  copy shadow weights to active bank.
REQ-011 SHALL have ports w_pass_valid / w_pass_data  output  1 / LANES*CW_W  registered weight forward to next PE.
REQ-012 SHALL have ports act_valid / act_data  input  1 / ACT_W  activation in.
REQ-013 SHALL have ports act_out_valid / act_out  output  1 / ACT_W  registered activation forward.
REQ-014 SHALL have ports psum_in / psum_out  input / output  LANES*PSUM_W  partial sums, lane-packed as REQ-009.
REQ-015 SHALL have port cfg_bypass  input  1  force pass-through of psum_in.
REQ-016 SHALL have ports w_active_valid / ovf  output  1 / LANES  active bank loaded; sticky per-lane overflow.

Function
REQ-017 SHALL form expected activation {act_data,1'b1} and expected weight {w_active[i],1'b1}, both unsigned.
REQ-018 SHALL compute per lane an unsigned product of width ACT_W+CW_W+2 and add psum_in[i] in PSUM_W+1 bits.
REQ-019 SHALL register psum_out[i] = sum when act_valid & w_active_valid & !cfg_bypass, else psum_in[i]; latency 1 cycle.
REQ-020 SHALL, on sum carry-out with SAT=1, output all-ones for that lane; with SAT=0, output low PSUM_W bits.
REQ-021 SHALL set ovf[i] on any carry-out in a computing cycle (either SAT mode); ovf clears only on reset or w_swap.
REQ-022 SHALL write shadow bank and set shadow_valid on w_load_valid; compute continues with active bank meanwhile.
REQ-023 SHALL register w_pass_data <= w_load_data and w_pass_valid <= w_load_valid every cycle (1-cycle forward).
REQ-024 SHALL, on w_swap with shadow_valid=1: active <= shadow, w_active_valid <= 1, shadow_valid <= 0.
REQ-025 SHALL ignore w_swap when shadow_valid=0 (active bank and w_active_valid unchanged; ovf still cleared).
REQ-026 SHALL, on simultaneous w_load_valid and w_swap: active <= old shadow, shadow <= new data, shadow_valid stays 1.
REQ-027 SHALL apply a swap from the next cycle: an act_valid in the swap cycle uses the pre-swap active bank.
REQ-028 SHALL register act_out <= act_data and act_out_valid <= act_valid every cycle regardless of weights or bypass.

Reset
REQ-029 SHALL clear on rst_n low, asynchronously: psum_out, act_out, act_out_valid, w_pass_data, w_pass_valid, both banks, shadow_valid, w_active_valid, ovf all to 0.
REQ-030 SHALL, after reset mid-operation, pass psum_in through until a new load and swap complete.

Structure
REQ-031 SHALL place default widths and lane-slice helper constants in the shared accelerator package.
REQ-032 SHALL instantiate one sub-module cpe_lane_mac per lane (combinational product, add, saturate, carry flag).

Verification
REQ-033 SHALL check: load w=2, swap, act=5, psum_in=100 -> next-cycle psum_out=155 (11*5+100), ovf=0.
REQ-034 SHALL check SAT=1: w=7, act=127, psum_in=8000 -> psum_out=8191, ovf=1; SAT=0 same stimulus -> 3633, ovf=1.
REQ-035 SHALL check: no swap after reset, act_valid=1, psum_in=42 -> psum_out=42, w_active_valid=0.
REQ-036 SHALL check: active w=1, load w=3 and swap in same cycle as act=5 -> that cycle uses w=1 (33+psum_in), next act uses w=3 (77+psum_in).
REQ-037 SHALL check: simultaneous load(w=4) and swap with shadow w=2 -> active=2, shadow=4, shadow_valid=1; second swap -> active=4.
REQ-038 SHALL check: rst_n asserted mid-stream -> all outputs 0 immediately, without waiting for a clk edge.
